imem_fetch_responder: RTL

- Memory-side responder for the core's instruction fetch: takes a PC request and returns the 32-bit instruction word.
- Sits between the core's pc_val/instr boundary and a word-addressed instruction store. The store is preloaded by the simulation harness through a load port.
- Adds a valid/ready handshake, fixed configurable latency, and error reporting, so a multi-cycle core can replace the combinational fetch path.

---
 rtl/imem_fetch_responder_pkg.sv | 26 ++
 rtl/imem_fetch_responder_if.sv | 42 ++++
 rtl/imem_fetch_responder_ram.sv | 44 ++++
 rtl/imem_fetch_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/imem_fetch_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared types and constants for the instruction fetch responder.
//            Defines the responder state encoding, the ebreak instruction
//            returned on faulting fetches, and the default instruction base
//            address (also the core's reset PC).
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Returned on any faulting fetch so the core traps cleanly.
    localparam logic [31:0] EBREAK_INSN       = 32'h0010_0073;

    // Byte address of instruction word 0; equals the core reset PC.
    localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h8000_0000;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_fetch_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_responder_if
// Purpose  : Fetch request/response handshake between the core (master) and
//            the instruction memory responder (slave).
//   req_valid / req_ready / req_addr    : request channel, byte PC
//   resp_valid / resp_ready             : response channel handshake
//   resp_instr / resp_err               : fetched word and fault flag
// Revision : 1.0 - initial release
// ============================================================================
interface imem_fetch_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_instr,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_instr,
        output resp_err
    );

endinterface : imem_fetch_responder_if
`default_nettype wire

// File: rtl/imem_fetch_responder_ram.sv
`default_nettype none
// ============================================================================
// Module   : imem_ram
// Purpose  : Simple dual-port instruction store, one synchronous write port
//            and one synchronous read port with read enable. A read and a
//            write to the same word on the same edge return the old word.
//            The array is never reset.
//   clk      : clock, rising edge
//   i_we     : write enable         i_waddr / i_wdata : write word index/data
//   i_re     : read enable          i_raddr           : read word index
//   o_rdata  : registered read data, holds while i_re is low
// Revision : 1.0 - initial release
// ============================================================================
module imem_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [ADDR_WIDTH-1:0] i_waddr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    input  wire logic                  i_re,
    input  wire logic [ADDR_WIDTH-1:0] i_raddr,
    output logic      [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Both updates are non-blocking, so a colliding read samples the array
    // before this edge's write lands.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_responder
// Purpose  : Memory-side responder for instruction fetch. Accepts a byte PC
//            with a valid/ready handshake, returns the instruction word a
//            fixed LATENCY cycles later, and flags misaligned or out-of-range
//            PCs with resp_err and an ebreak instruction.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : fetch handshake (slave side)
//   load_en / load_addr / load_data : preload write port, any state
//   busy       : FSM not idle
//   fetch_cnt  : completed responses, wraps at 2**32
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,                 // up to 30
    parameter logic [31:0] BASE       = IMEM_BASE_DEFAULT,
    parameter int          LATENCY    = 2                   // 1..15
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    imem_fetch_responder_if.slave      bus,
    input  wire logic                  load_en,
    input  wire logic [ADDR_WIDTH-1:0] load_addr,
    input  wire logic [31:0]           load_data,
    output logic                       busy,
    output logic [31:0]                fetch_cnt
);

    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);
    // Size of the store in bytes, one bit wider so ADDR_WIDTH=30 still fits.
    localparam logic [32:0] c_SPAN     = 33'd1 << (ADDR_WIDTH + 2);

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_index;
    logic                  r_err;
    logic [31:0]           r_fetch_cnt;

    logic [31:0]           w_offset;
    logic [ADDR_WIDTH-1:0] w_req_index;
    logic                  w_req_err;
    logic                  w_accept;
    logic                  w_in_resp;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [31:0]           w_rd_data;

    // ------------------------------------------------------------------
    // Request decode: unsigned 32-bit offset from BASE, alignment and range.
    // A PC below BASE wraps to a huge offset, but it is flagged explicitly
    // as well so the intent is obvious.
    // ------------------------------------------------------------------
    assign w_offset    = bus.req_addr - BASE;
    assign w_req_index = w_offset[ADDR_WIDTH+1:2];
    assign w_req_err   = (bus.req_addr[1:0] != 2'b00)
                       | (bus.req_addr < BASE)
                       | ({1'b0, w_offset} >= c_SPAN);
    assign w_accept    = (r_state == IDLE) && bus.req_valid;

    // ------------------------------------------------------------------
    // Next-state, latency counter and RAM read control.
    // The RAM read is issued on the edge that enters RESP, so its output
    // register is the response data register. With LATENCY==1 that edge is
    // the accept edge, so the read index comes straight from the request.
    // Faulting fetches never touch the RAM.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rd_en      = 1'b0;
        w_rd_addr    = r_index;

        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_cnt_next = c_CNT_INIT;
                    if (LATENCY == 1) begin
                        w_state_next = RESP;
                        w_rd_en      = !w_req_err;
                        w_rd_addr    = w_req_index;
                    end else begin
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = RESP;
                    w_rd_en      = !r_err;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_index     <= '0;
            r_err       <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_index <= w_req_index;
                r_err   <= w_req_err;
            end
            if ((r_state == RESP) && bus.resp_ready) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    imem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (32)
    ) u_ram (
        .clk     (clk),
        .i_we    (load_en),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Outputs. Response fields are gated by RESP so they read as zero after
    // reset; the RAM output register only moves on a read, so later loads
    // cannot disturb a pending response.
    // ------------------------------------------------------------------
    assign w_in_resp      = (r_state == RESP);
    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = w_in_resp;
    assign bus.resp_err   = w_in_resp & r_err;
    assign bus.resp_instr = !w_in_resp ? 32'd0
                          : r_err      ? EBREAK_INSN
                          :              w_rd_data;
    assign busy           = (r_state != IDLE);
    assign fetch_cnt      = r_fetch_cnt;

endmodule : imem_fetch_responder
`default_nettype wire
